// File: rtl/fu_branch_q_if.sv
// -----------------------------------------------------------------------------
// fu_branch_q_if.sv
// Bundles for the branch functional unit.
//   fu_branch_q_iss_if : issue bus from the scheduler into the unit
//      master = issuing stage, slave = fu_branch_q
//      exe_v_i / exe_ready_o handshake, opcode_i, cond_i, flags_i, pc_i,
//      operand2_i, pred_taken_i, pred_target_i, rob_dest_i, reg_dest_i
//   fu_branch_q_wb_if  : writeback bus from the unit toward the ROB arbiter
//      master = fu_branch_q, slave = writeback arbiter
//      wb_v_o / wb_ready_i handshake, wb_rob_dest_o, wb_taken_o, wb_target_o,
//      wb_mispredict_o, wb_reg_v_o, wb_reg_dest_o, wb_link_o
// Opcode encodings (WIDTH_OP, BCC_OP, BL_OP) are supplied here unless the
// build already defines them.
// -----------------------------------------------------------------------------
`ifndef WIDTH_OP
`define WIDTH_OP 4
`endif
`ifndef BCC_OP
`define BCC_OP 4'h1
`endif
`ifndef BL_OP
`define BL_OP 4'h2
`endif

interface fu_branch_q_iss_if #(
   parameter int WORD_SIZE_P = 16,
   parameter int ROB_IDX_W   = 5,
   parameter int PREG_IDX_W  = 6
);
   logic                   exe_v_i;
   logic                   exe_ready_o;
   logic [`WIDTH_OP-1:0]   opcode_i;
   logic [2:0]             cond_i;
   logic [3:0]             flags_i;
   logic [WORD_SIZE_P-1:0] pc_i;
   logic [WORD_SIZE_P-1:0] operand2_i;
   logic                   pred_taken_i;
   logic [WORD_SIZE_P-1:0] pred_target_i;
   logic [ROB_IDX_W-1:0]   rob_dest_i;
   logic [PREG_IDX_W-1:0]  reg_dest_i;

   modport master (
      output exe_v_i, opcode_i, cond_i, flags_i, pc_i, operand2_i,
             pred_taken_i, pred_target_i, rob_dest_i, reg_dest_i,
      input  exe_ready_o
   );
   modport slave (
      input  exe_v_i, opcode_i, cond_i, flags_i, pc_i, operand2_i,
             pred_taken_i, pred_target_i, rob_dest_i, reg_dest_i,
      output exe_ready_o
   );
endinterface

interface fu_branch_q_wb_if #(
   parameter int WORD_SIZE_P = 16,
   parameter int ROB_IDX_W   = 5,
   parameter int PREG_IDX_W  = 6
);
   logic                   wb_v_o;
   logic                   wb_ready_i;
   logic [ROB_IDX_W-1:0]   wb_rob_dest_o;
   logic                   wb_taken_o;
   logic [WORD_SIZE_P-1:0] wb_target_o;
   logic                   wb_mispredict_o;
   logic                   wb_reg_v_o;
   logic [PREG_IDX_W-1:0]  wb_reg_dest_o;
   logic [WORD_SIZE_P-1:0] wb_link_o;

   modport master (
      output wb_v_o, wb_rob_dest_o, wb_taken_o, wb_target_o, wb_mispredict_o,
             wb_reg_v_o, wb_reg_dest_o, wb_link_o,
      input  wb_ready_i
   );
   modport slave (
      input  wb_v_o, wb_rob_dest_o, wb_taken_o, wb_target_o, wb_mispredict_o,
             wb_reg_v_o, wb_reg_dest_o, wb_link_o,
      output wb_ready_i
   );
endinterface

// File: rtl/fu_branch_q.sv
// -----------------------------------------------------------------------------
// fu_branch_q.sv
// Branch functional unit with a small result queue.
// Resolves conditional (BCC), branch-and-link (BL) and register-indirect
// branches, computes taken / target / link and flags mispredictions against
// the front-end prediction. Results wait in a Q_DEPTH-entry FIFO until the
// writeback arbiter accepts them.
//
// Ports:
//   clk_i       clock
//   reset_n_i   asynchronous active-low reset (released on clk_i)
//   flush_i     squash: empties the queue and drops the same-cycle issue
//   iss         fu_branch_q_iss_if.slave  (issue bus, exe_v_i/exe_ready_o)
//   wb          fu_branch_q_wb_if.master  (result bus, wb_v_o/wb_ready_i)
//   perf_branches_o, perf_mispredicts_o   32-bit dequeue counters, present
//               only when the macro FU_BRANCH_PERF_EN is defined
// -----------------------------------------------------------------------------
`ifndef WIDTH_OP
`define WIDTH_OP 4
`endif
`ifndef BCC_OP
`define BCC_OP 4'h1
`endif
`ifndef BL_OP
`define BL_OP 4'h2
`endif

module fu_branch_q #(
   parameter int WORD_SIZE_P = 16,
   parameter int ROB_IDX_W   = 5,
   parameter int PREG_IDX_W  = 6,
   parameter int Q_DEPTH     = 2
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              flush_i,
   fu_branch_q_iss_if.slave  iss,
   fu_branch_q_wb_if.master  wb
`ifdef FU_BRANCH_PERF_EN
   ,
   output logic [31:0]       perf_branches_o,
   output logic [31:0]       perf_mispredicts_o
`endif
);

   localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam int CNT_W = $clog2(Q_DEPTH + 1);

   typedef struct packed {
      logic [ROB_IDX_W-1:0]   rob_dest;
      logic                   taken;
      logic [WORD_SIZE_P-1:0] target;
      logic                   mispredict;
      logic                   link_v;
      logic [PREG_IDX_W-1:0]  reg_dest;
      logic [WORD_SIZE_P-1:0] link;
   } entry_t;

   // Circular pointer advance, wrapping at Q_DEPTH (not at a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(Q_DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   // Condition evaluation on {N,Z,C,V}.
   function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] fl);
      logic n, z, c, v, met;
      n = fl[3];
      z = fl[2];
      c = fl[1];
      v = fl[0];
      case (cond)
         3'd0:    met = 1'b1;
         3'd1:    met = z;
         3'd2:    met = ~z;
         3'd3:    met = n ^ v;
         3'd4:    met = ~(n ^ v);
         3'd5:    met = c;
         3'd6:    met = ~c;
         3'd7:    met = 1'b0;
         default: met = 1'b0;
      endcase
      return met;
   endfunction

   entry_t           entry_q [Q_DEPTH];
   entry_t           entry_d [Q_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   entry_t           new_entry;
   entry_t           head;
   logic             cond_met;
   logic             exe_ready;
   logic             wb_v;
   logic             enq;
   logic             deq;

   // Resolve the branch presented on the issue bus.
   always_comb begin
      new_entry          = '0;
      cond_met           = cond_eval(iss.cond_i, iss.flags_i);
      new_entry.rob_dest = iss.rob_dest_i;
      new_entry.reg_dest = iss.reg_dest_i;
      if (iss.opcode_i == `BCC_OP) begin
         new_entry.taken = cond_met;
         if (cond_met) begin
            new_entry.target = iss.pc_i + iss.operand2_i + WORD_SIZE_P'(1);
         end else begin
            new_entry.target = iss.pc_i + WORD_SIZE_P'(1);
         end
      end else if (iss.opcode_i == `BL_OP) begin
         new_entry.taken  = 1'b1;
         new_entry.target = iss.operand2_i;
         new_entry.link_v = 1'b1;
         new_entry.link   = iss.pc_i + WORD_SIZE_P'(2);
      end else begin
         new_entry.taken  = 1'b1;
         new_entry.target = iss.operand2_i;
      end
      new_entry.mispredict = (new_entry.taken != iss.pred_taken_i) ||
                             (new_entry.taken && (new_entry.target != iss.pred_target_i));
   end

   // Handshake qualifiers; ready looks only at occupancy, never at wb_ready_i.
   always_comb begin
      exe_ready = (count_q != CNT_W'(Q_DEPTH));
      wb_v      = (count_q != CNT_W'(0));
      head      = entry_q[rd_ptr_q];
      enq       = iss.exe_v_i && exe_ready && !flush_i;
      deq       = wb_v && wb.wb_ready_i && !flush_i;
   end

   // Queue next-state: flush wins over both enqueue and dequeue.
   always_comb begin
      entry_d  = entry_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            entry_d[wr_ptr_q] = new_entry;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
         end else begin
            count_d = count_q;
         end
      end
   end

   // Queue state registers; reset clears storage so wb_* data read as 0.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Q_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < Q_DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

   assign iss.exe_ready_o   = exe_ready;
   assign wb.wb_v_o         = wb_v;
   assign wb.wb_rob_dest_o  = head.rob_dest;
   assign wb.wb_taken_o     = head.taken;
   assign wb.wb_target_o    = head.target;
   assign wb.wb_mispredict_o = head.mispredict;
   assign wb.wb_reg_v_o     = wb_v && head.link_v;
   assign wb.wb_reg_dest_o  = head.reg_dest;
   assign wb.wb_link_o      = head.link;

`ifdef FU_BRANCH_PERF_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

   // Counters follow accepted dequeues only; flush does not clear them.
   always_comb begin
      perf_branches_d    = perf_branches_q;
      perf_mispredicts_d = perf_mispredicts_q;
      if (deq) begin
         perf_branches_d = perf_branches_q + 32'd1;
         if (head.mispredict) begin
            perf_mispredicts_d = perf_mispredicts_q + 32'd1;
         end else begin
            perf_mispredicts_d = perf_mispredicts_q;
         end
      end else begin
         perf_branches_d    = perf_branches_q;
         perf_mispredicts_d = perf_mispredicts_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         perf_branches_q    <= 32'd0;
         perf_mispredicts_q <= 32'd0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_branches_o    = perf_branches_q;
   assign perf_mispredicts_o = perf_mispredicts_q;
`endif

endmodule

// File: doc/fu_branch_q.md
# fu_branch_q

Parametrised branch functional unit for the execute stage: resolves conditional, link and register-indirect branches, computes taken/target/link values and flags mispredictions against the front-end prediction. Results are held in a small output queue with a valid/ready handshake toward the ROB writeback arbiter, so writeback back-pressure no longer forces the unit to drop or overwrite results. A flush input discards all in-flight results on a pipeline squash.

## Interface
- WORD_SIZE_P, 16, data/address width
- ROB_IDX_W, 5, ROB tag width
- PREG_IDX_W, 6, physical register index width
- Q_DEPTH, 2, output queue entries (>=1)
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  squash all queued results and the current issue
- exe_v_i  in  1  issue valid
- exe_ready_o  out  1  unit can accept an issue
- opcode_i  in  WIDTH_OP  `BCC_OP, `BL_OP, anything else = indirect
- cond_i  in  3  condition code (BCC only)
- flags_i  in  4  {N,Z,C,V}
- pc_i, operand2_i  in  WORD_SIZE_P  branch PC, offset/target operand
- pred_taken_i  in  1, pred_target_i  in  WORD_SIZE_P  front-end prediction
- rob_dest_i  in  ROB_IDX_W; reg_dest_i  in  PREG_IDX_W
- wb_v_o  out  1  head entry valid
- wb_ready_i  in  1  consumer accepts head
- wb_rob_dest_o  out  ROB_IDX_W; wb_taken_o  out  1; wb_target_o  out  WORD_SIZE_P; wb_mispredict_o  out  1
- wb_reg_v_o  out  1  head is a link write (wb_v_o && BL)
- wb_reg_dest_o  out  PREG_IDX_W; wb_link_o  out  WORD_SIZE_P
- perf_branches_o, perf_mispredicts_o  out  32 each (only with FU_BRANCH_PERF_EN)

## Operation
- Condition (cond_i): 0 always, 1 EQ (Z), 2 NE (!Z), 3 LT (N^V), 4 GE (!(N^V)), 5 CS (C), 6 CC (!C), 7 never.
- BCC: taken = condition; target = taken ? pc+operand2+1 : pc+1; no link.
- BL: taken=1; target=operand2; link = pc+2; reg write.
- Other opcodes: taken=1; target=operand2; no link.
- All adds modulo 2^WORD_SIZE_P (wrap, no overflow flag).
- mispredict = (taken != pred_taken_i) || (taken && target != pred_target_i).
- Enqueue when exe_v_i && exe_ready_o && !flush_i. Dequeue when wb_v_o && wb_ready_i. FIFO order; circular pointers wrap at Q_DEPTH.
- exe_ready_o = (count != Q_DEPTH); it does not depend on same-cycle dequeue.
- Simultaneous enqueue and dequeue with 0 < count < Q_DEPTH: count unchanged, both happen.
- flush_i has priority: next edge count=0, pointers=0, same-cycle issue and dequeue discarded.
- Outputs wb_* other than valids are don't-care when wb_v_o=0, but are driven from queue storage (no X).

## Timing
- Latency: issue accepted at edge N -> wb_v_o high after edge N (cycle N+1) when queue was empty.
- Full throughput (1/cycle) when wb_ready_i held high and Q_DEPTH>=1... with Q_DEPTH=1 throughput is 1 per 2 cycles (ready not bypassed).
- Head holds stable while wb_v_o && !wb_ready_i.
- Reset (asynchronous assert, release on clk_i): count=0, pointers=0, wb_v_o=0, wb_reg_v_o=0, exe_ready_o=1, all wb_* data 0, perf counters 0.
- Reset mid-operation discards all entries immediately (asynchronously).

## Configuration
- FU_BRANCH_PERF_EN defined: perf_branches_o increments on each dequeue; perf_mispredicts_o increments on each dequeue with wb_mispredict_o=1; 32-bit wrap; cleared only by reset, not by flush_i.
- Undefined: perf ports and counters absent; all other behaviour identical.

## Test plan
- Reset then BCC EQ, flags Z=1, pc=0x0010, op2=0x0005, pred taken/0x0016, wb_ready_i=1 -> next cycle wb_v_o=1, taken=1, target=0x0016, mispredict=0, wb_reg_v_o=0.
- BL pc=0x0100, op2=0x0200, reg_dest=7, pred taken/0x0200 -> target=0x0200, wb_reg_v_o=1, dest 7, link=0x0102.
- BCC NE Z=1 pc=0xFFFF predicted taken -> taken=0, target=0x0000 (wrap), mispredict=1.
- wb_ready_i=0, three back-to-back issues (Q_DEPTH=2) -> exe_ready_o low after second accept; third held; release ready -> entries drain in order, third accepted.
- Two entries queued, flush_i pulse with simultaneous exe_v_i -> next cycle wb_v_o=0, exe_ready_o=1, no later output of any of the three.
- FU_BRANCH_PERF_EN: drain 5 branches, 2 mispredicted, then flush -> perf_branches_o=5, perf_mispredicts_o=2 unchanged by flush; reset_n_i low -> both 0.
